// File: rtl/uart_tx_fifo_if.sv
// Host-side bus of the buffered UART transmitter: byte push, overflow
// clear, FIFO status and the serial line itself.
interface uart_tx_fifo_if #(
    parameter int FifoDepthLog2 = 3
);
    logic                   wr_en;
    logic [7:0]             wr_data;
    logic                   ovf_clear;
    logic                   full;
    logic                   empty;
    logic [FifoDepthLog2:0] count;
    logic                   overflow;
    logic                   tx_busy;
    logic                   tx_done;
    logic                   txd;

    // CPU side: pushes bytes and reads status
    modport master (
        output wr_en, wr_data, ovf_clear,
        input  full, empty, count, overflow, tx_busy, tx_done, txd
    );

    // Transmitter side
    modport slave (
        input  wr_en, wr_data, ovf_clear,
        output full, empty, count, overflow, tx_busy, tx_done, txd
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 serial transmitter. Bytes pushed by the CPU queue in a
// circular FIFO; a four-state FSM pops them and shifts them out LSB first
// at ClkFrequency/Baud cycles per bit, chaining frames with no idle gap.
module uart_tx_fifo #(
    parameter int ClkFrequency  = 50000000,
    parameter int Baud          = 9600,
    parameter int FifoDepthLog2 = 3
) (
    input  logic           clk_50M,
    input  logic           rst_n,
    uart_tx_fifo_if.slave  bus
);
    localparam int DIV   = ClkFrequency / Baud;
    localparam int DEPTH = 2 ** FifoDepthLog2;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [CNT_W-1:0]         BAUD_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0]         BAUD_ONE  = CNT_W'(1);
    localparam logic [FifoDepthLog2-1:0] PTR_ONE   = FifoDepthLog2'(1);
    localparam logic [FifoDepthLog2:0]   CNT_ONE   = (FifoDepthLog2 + 1)'(1);
    localparam logic [FifoDepthLog2:0]   CNT_FULL  = (FifoDepthLog2 + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         baud_q, baud_d;
    logic [2:0]               bit_q, bit_d;
    logic [7:0]               shift_q, shift_d;
    logic                     txd_q, txd_d;
    logic                     pop;
    logic                     push;
    logic                     baud_last;

    logic [7:0]               mem [DEPTH];
    logic [FifoDepthLog2-1:0] wr_ptr_q, rd_ptr_q;
    logic [FifoDepthLog2:0]   count_q, count_d;
    logic                     full_q, empty_q, ovf_q;

    // Full is judged on the registered pre-edge value, so a pop on the
    // same edge never frees room for a push.
    assign push      = bus.wr_en && !full_q;
    assign baud_last = (baud_q == BAUD_LAST);

    // FIFO storage: payload only, no reset needed
    always_ff @(posedge clk_50M) begin
        if (push) begin
            mem[wr_ptr_q] <= bus.wr_data;
        end
    end

    // FIFO pointers wrap naturally at the pointer width
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    // Next occupancy: simultaneous push and pop leave it unchanged
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (!push && pop) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // Registered status flags, derived from the next occupancy so they
    // always agree with the pointers
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            full_q  <= (count_d == CNT_FULL);
            empty_q <= (count_d == '0);
            if (bus.wr_en && full_q) begin
                ovf_q <= 1'b1;
            end else if (bus.ovf_clear) begin
                ovf_q <= 1'b0;
            end
        end
    end

    // Next-state, pop and next-txd decode for the serialiser
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                if (!empty_q) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr_q];
                    state_d = START;
                    baud_d  = '0;
                    txd_d   = 1'b0;
                end
            end
            START: begin
                if (baud_last) begin
                    state_d = DATA;
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    txd_d   = shift_q[0];
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        txd_d   = 1'b1;
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                        txd_d   = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (!empty_q) begin
                        // Chain straight into the next start bit
                        pop     = 1'b1;
                        shift_d = mem[rd_ptr_q];
                        state_d = START;
                        txd_d   = 1'b0;
                    end else begin
                        state_d = IDLE;
                        txd_d   = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

    // Serialiser control registers; txd comes straight from a flop
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            txd_q   <= txd_d;
        end
    end

    // Shift register holds frame payload only, no reset needed
    always_ff @(posedge clk_50M) begin
        shift_q <= shift_d;
    end

    assign bus.full     = full_q;
    assign bus.empty    = empty_q;
    assign bus.count    = count_q;
    assign bus.overflow = ovf_q;
    assign bus.tx_busy  = (state_q != IDLE);
    assign bus.tx_done  = (state_q == STOP) && baud_last;
    assign bus.txd      = txd_q;
endmodule
